// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the flex up/down counter family.
package flex_counter_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_t;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int unsigned DEF_NUM_CNT_BITS  = 4;
  localparam int unsigned DEF_WRAP_CNT_BITS = 8;

endpackage

// File: rtl/flex_wrap_tally.sv
// Saturating tally of wrap/saturate-hit events, used only with FLEX_CNT_WRAP_TALLY_EN.
module flex_wrap_tally
  import flex_counter_pkg::*;
#(
  parameter int unsigned WRAP_CNT_BITS = DEF_WRAP_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     inc_i,
  output logic [WRAP_CNT_BITS-1:0] count_o
);

  logic [WRAP_CNT_BITS-1:0] tally_q, tally_d;

  always_comb begin
    tally_d = tally_q;
    if (clear_i) begin
      tally_d = '0;
    end else if (inc_i && (tally_q != '1)) begin
      tally_d = tally_q + {{(WRAP_CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign count_o = tally_q;

endmodule

// File: rtl/flex_counter_ud.sv
// Up/down counter with run-time terminal, wrap/saturate mode, parallel load and
// registered terminal flag / wrap pulse. FLEX_CNT_WRAP_TALLY_EN adds wrap_count.
module flex_counter_ud
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
  parameter int unsigned WRAP_CNT_BITS = DEF_WRAP_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     saturate,
  input  logic                     load_en,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
`ifdef FLEX_CNT_WRAP_TALLY_EN
  output logic [WRAP_CNT_BITS-1:0] wrap_count,
`endif
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  if ((NUM_CNT_BITS < 2) || (NUM_CNT_BITS > 32) || (WRAP_CNT_BITS < 1)) begin : g_bad_width
    $error("flex_counter_ud: width parameter out of range");
  end

  cnt_dir_t                dir;
  cnt_mode_t               mode;
  logic [NUM_CNT_BITS-1:0] count_q, count_d, terminal;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic                    sat_q, sat_d;

  assign dir  = cnt_dir_t'(count_down);
  assign mode = cnt_mode_t'(saturate);

  // sat_q remembers that the last step was a saturate hit, so only the first
  // arrival at the terminal pulses; any other count change re-arms it.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load_en) begin
      count_d = (load_val > rollover_val) ? rollover_val : load_val;
      sat_d   = 1'b0;
    end else if (count_enable) begin
      sat_d = 1'b0;
      if (rollover_val == '0) begin
        count_d = '0;
      end else if (dir == CNT_UP) begin
        if (count_q < rollover_val) begin
          count_d = count_q + ONE;
        end else if (mode == CNT_WRAP) begin
          count_d = ONE;
          pulse_d = 1'b1;
        end else begin
          count_d = rollover_val;
          pulse_d = !sat_q;
          sat_d   = 1'b1;
        end
      end else begin
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else if (mode == CNT_WRAP) begin
          count_d = rollover_val;
          pulse_d = 1'b1;
        end else begin
          count_d = ONE;
          pulse_d = !sat_q;
          sat_d   = 1'b1;
        end
      end
    end
    terminal = (dir == CNT_UP) ? rollover_val : ONE;
    flag_d   = !clear && (rollover_val != '0) && (count_d == terminal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      sat_q   <= sat_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;

`ifdef FLEX_CNT_WRAP_TALLY_EN
  flex_wrap_tally #(
    .WRAP_CNT_BITS(WRAP_CNT_BITS)
  ) u_tally (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear),
    .inc_i  (pulse_d),
    .count_o(wrap_count)
  );
`endif

endmodule

// File: tb/tb_flex_counter_ud.sv
// Bench for flex_counter_ud: directed vector table, a saturate corner sequence and
// randomized stimulus against a behavioural model. Honours FLEX_CNT_WRAP_TALLY_EN.
module tb_flex_counter_ud;

  logic       clk = 1'b0;
  logic       rst, clear, count_enable, count_down, saturate, load_en;
  logic [3:0] load_val, rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag, wrap_pulse;
`ifdef FLEX_CNT_WRAP_TALLY_EN
  logic [7:0] wrap_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flex_counter_ud #(
    .NUM_CNT_BITS (4),
    .WRAP_CNT_BITS(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .count_down   (count_down),
    .saturate     (saturate),
    .load_en      (load_en),
    .load_val     (load_val),
    .rollover_val (rollover_val),
`ifdef FLEX_CNT_WRAP_TALLY_EN
    .wrap_count   (wrap_count),
`endif
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  typedef struct {
    logic       rst, clr, en, dn, sat, ld;
    logic [3:0] lv, rv;
    int         ec;
    logic       ef, ep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic e, logic d, logic s, logic l,
                              int lv, int rv, int ec, logic ef, logic ep);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.dn = d; v.sat = s; v.ld = l;
    v.lv = 4'(lv); v.rv = 4'(rv); v.ec = ec; v.ef = ef; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic e, input logic d,
                       input logic s, input logic l, input int lv, input int rv);
    rst = r; clear = c; count_enable = e; count_down = d; saturate = s; load_en = l;
    load_val = 4'(lv); rollover_val = 4'(rv);
  endtask

  // Behavioural reference state, derived from the counting rules
  int m_cnt, m_tally;
  bit m_flag, m_pulse, m_sat;

  task automatic model_step(input bit r, input bit c, input bit e, input bit d,
                            input bit s, input bit l, input int lv, input int rv);
    m_pulse = 0;
    if (r || c) begin
      m_cnt = 0; m_sat = 0; m_flag = 0; m_tally = 0;
      return;
    end
    if (l) begin
      m_cnt = (lv < rv) ? lv : rv;
      m_sat = 0;
    end else if (e) begin
      bit was_sat = m_sat;
      m_sat = 0;
      if (rv == 0) m_cnt = 0;
      else if (!d) begin
        if (m_cnt < rv) m_cnt = m_cnt + 1;
        else if (!s) begin m_cnt = 1; m_pulse = 1; end
        else begin m_cnt = rv; m_pulse = !was_sat; m_sat = 1; end
      end else begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (!s) begin m_cnt = rv; m_pulse = 1; end
        else begin m_cnt = 1; m_pulse = !was_sat; m_sat = 1; end
      end
    end
    m_flag = (rv != 0) && (m_cnt == (d ? 1 : rv));
    if (m_pulse && m_tally < 255) m_tally++;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // rst, clr, en, dn, sat, ld, lv, rv -> count, flag, pulse
    vecs.push_back(mk(1,0,1,0,0,0, 0, 5,  0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0, 5,  0,0,0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,0,1,0,0,0, 0, 5, i, i==5, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 0, 3,  0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 3,  1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 3,  2,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 3,  3,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 3,  1,0,1));
    vecs.push_back(mk(0,0,0,1,0,1, 2, 4,  2,0,0));
    vecs.push_back(mk(0,0,1,1,0,0, 0, 4,  1,1,0));
    vecs.push_back(mk(0,0,1,1,0,0, 0, 4,  4,0,1));
    vecs.push_back(mk(0,0,1,1,0,0, 0, 4,  3,0,0));
    vecs.push_back(mk(0,1,0,0,1,0, 0, 3,  0,0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  1,0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  2,0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  3,1,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  3,1,1));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  3,1,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0, 3,  3,1,0));
    vecs.push_back(mk(0,1,1,0,0,1, 2, 3,  0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 9, 6,  6,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,10,  0,0,0));
    for (int i = 1; i <= 7; i++) vecs.push_back(mk(0,0,1,0,0,0, 0,10, i, 0, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 4,  1,0,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 0,  0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 7, 0,  0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1, 5,  1,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0, 5,  1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1, 1,  1,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 1,  1,1,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0, 1,  1,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 9,12,  9,0,0));
    vecs.push_back(mk(1,0,1,0,0,1, 3,12,  0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].dn, vecs[i].sat, vecs[i].ld,
            int'(vecs[i].lv), int'(vecs[i].rv));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), int'(count_out), vecs[i].ec);
      chk($sformatf("vec%0d_flag", i), int'(rollover_flag), int'(vecs[i].ef));
      chk($sformatf("vec%0d_pulse", i), int'(wrap_pulse), int'(vecs[i].ep));
    end

    // Saturate hit must pulse only once, even across idle cycles at the terminal
    drive(0, 1, 0, 0, 1, 0, 0, 2); @(posedge clk); #1;
    drive(0, 0, 1, 0, 1, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_seq_count%0d", i), int'(count_out), (i == 0) ? 1 : 2);
      chk($sformatf("sat_seq_pulse%0d", i), int'(wrap_pulse), (i == 2) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 2); @(posedge clk); @(posedge clk); #1;
    chk("sat_idle_pulse", int'(wrap_pulse), 0);
    drive(0, 0, 1, 0, 1, 0, 0, 2); @(posedge clk); #1;
    chk("sat_rehit_count", int'(count_out), 2);
    chk("sat_rehit_pulse", int'(wrap_pulse), 0);
    chk("sat_rehit_flag", int'(rollover_flag), 1);
`ifdef FLEX_CNT_WRAP_TALLY_EN
    chk("sat_tally", int'(wrap_count), 1);
`endif

    // Randomized phase against the behavioural model
    drive(1, 0, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit r, c, e, d, s, l;
      int lv, rv;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 24) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = (n / 40) % 2 == 1 ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      s  = ((n / 100) % 2 == 1);
      lv = $urandom_range(0, 15);
      rv = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1) : (n % 60 < 30 ? 9 : $urandom_range(2, 15));
      drive(r, c, e, d, s, l, lv, rv);
      model_step(r, c, e, d, s, l, lv, rv);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_count", n), int'(count_out), m_cnt);
      chk($sformatf("rnd%0d_flag", n), int'(rollover_flag), int'(m_flag));
      chk($sformatf("rnd%0d_pulse", n), int'(wrap_pulse), int'(m_pulse));
`ifdef FLEX_CNT_WRAP_TALLY_EN
      chk($sformatf("rnd%0d_tally", n), int'(wrap_count), m_tally);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flex_counter_ud.md
Name: flex_counter_ud

Overview:
Parametrised successor to the flex counter: an up/down counter with selectable wrap or saturate behaviour, synchronous parallel load and a registered terminal flag.
- Terminal value is set at run time by rollover_val.
- Adds a one-cycle wrap pulse for chaining counters in the timer and sample-index logic of the FIR/AHB-Lite datapath.
- Used wherever a programmable-period counter with direction control is needed.

Parameters:
NUM_CNT_BITS, 4, width of count_out, load_val and rollover_val (range 2..32)
WRAP_CNT_BITS, 8, width of the optional wrap tally (used only with FLEX_CNT_WRAP_TALLY_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
clear  input  1  synchronous clear of count and flags
count_enable  input  1  advance counter one step this cycle
count_down  input  1  0 = count up, 1 = count down; sampled each enabled cycle
saturate  input  1  0 = wrap at terminal, 1 = hold at terminal
load_en  input  1  synchronous parallel load
load_val  input  NUM_CNT_BITS  value loaded when load_en=1
rollover_val  input  NUM_CNT_BITS  terminal (maximum) count
count_out  output  NUM_CNT_BITS  current count, registered
rollover_flag  output  1  registered; high while count_out equals the active terminal
wrap_pulse  output  1  registered; high for exactly the cycle after a wrap or saturate-hit step

Behaviour:
- Reset (rst=1 at rising edge): count_out=0, rollover_flag=0, wrap_pulse=0. Reset overrides all other inputs. Reset mid-count discards state with no partial update.
- Priority each edge: rst > clear > load_en > count_enable > hold.
- clear: count_out=0, rollover_flag=0, wrap_pulse=0.
- load_en: count_out=min(load_val, rollover_val); wrap_pulse=0; rollover_flag recomputed from the loaded value.
- Active terminal:
  - up mode: rollover_val
  - down mode: 1
- Up step, enabled:
  - count_out<rollover_val: +1.
  - count_out>=rollover_val: wrap mode -> 1, wrap_pulse=1; saturate mode -> rollover_val, wrap_pulse=1 only on the first arrival.
- Down step, enabled:
  - count_out>1: -1.
  - count_out<=1: wrap mode -> rollover_val, wrap_pulse=1; saturate mode -> 1, wrap_pulse=1 only on the first arrival.
- count_out>rollover_val, caused by rollover_val lowered mid-count:
  - up step treats it as terminal, applying the wrap/saturate rule above.
  - down step decrements normally.
- rollover_val=0: count_out is forced to 0 on every enabled step or load; rollover_flag=0; wrap_pulse=0.
- rollover_val=1: up wrap mode holds at 1 with wrap_pulse=1 every enabled cycle.
- rollover_flag: registered compare of the next count_out against the active terminal, using the count_down value sampled in the same cycle. It is valid in the same cycle as count_out; no extra latency.
- Disabled cycle (no clear/load/enable): count_out holds; wrap_pulse=0; rollover_flag is recomputed using the current count_down.
- All arithmetic is unsigned NUM_CNT_BITS. No internal overflow is possible because wrap and saturate are handled explicitly.

Optional Feature:
FLEX_CNT_WRAP_TALLY_EN
- Defined:
  - Adds output wrap_count [WRAP_CNT_BITS-1:0], which increments on each cycle wrap_pulse is set and saturates at all-ones.
  - Zeroed by rst and clear; unaffected by load_en.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package flex_counter_pkg:
  - cnt_dir_t enum (CNT_UP, CNT_DOWN)
  - cnt_mode_t enum (CNT_WRAP, CNT_SAT)
  - default-width localparams
- Sub-module flex_wrap_tally: the saturating wrap counter, instantiated only under FLEX_CNT_WRAP_TALLY_EN.

Test Plan:
- rst=1 for 2 cycles with count_enable=1, rollover_val=5 -> count_out=0, rollover_flag=0, wrap_pulse=0 throughout; hold rst=0, enable 5 cycles -> count_out=5, rollover_flag=1.
- rollover_val=3, up wrap, 4 enabled cycles from 0 -> 1,2,3,1; wrap_pulse=1 only after the 4th edge; rollover_flag=1 only at count 3.
- rollover_val=4, down wrap, load 2 then 3 enabled cycles -> 1,4,3; rollover_flag=1 at count 1; wrap_pulse once on the 1->4 step.
- rollover_val=3, up saturate, 6 enabled cycles -> 1,2,3,3,3,3; wrap_pulse exactly once; with FLEX_CNT_WRAP_TALLY_EN, wrap_count=1.
- Simultaneous clear=1, load_en=1 (load_val=2), count_enable=1 at count 3 -> count_out=0, flags 0; then load_val=9 with rollover_val=6 -> count_out=6, rollover_flag=1 (up mode).
- Count to 7 with rollover_val=10, lower rollover_val to 4, one up step -> count_out=1, wrap_pulse=1; rollover_val=0 with enable -> count_out=0, rollover_flag=0.
